// File: rtl/alu_mdu.sv
// Registered execute-stage ALU with an iterative unsigned multiply/divide unit.
// Ports: clk, rst, start, ALUctr, ovf_chk, A, B -> busy, done, lo, hi, Zero, OF, div_zero.
// Optional: define ALU_MDU_DIV_EN to build the restoring divider (DIVU).
module alu_mdu #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   ALUctr,
  input  logic         ovf_chk,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         Zero,
  output logic         OF,
  output logic         div_zero
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_PASSB = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_MULU  = 4'b1000;
`ifdef ALU_MDU_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  // ph: product high / partial remainder
  // pl: multiplier / dividend-quotient
  logic [W-1:0]  ph, pl, mcand;
  logic [W-1:0]  ph_n, pl_n;
  logic [W:0]    madd;
`ifdef ALU_MDU_DIV_EN
  logic          is_div;
  logic [W:0]    shl, trial;
`endif

  logic [W-1:0]  sum, diff, r_lo, r_hi;
  logic          r_of, r_dz, r_iter, trap;
  logic          accept, last;

  assign busy   = (state == RUN);
  assign accept = start && (state == IDLE);
  assign last   = (cnt == LAST);

  always_comb begin
    sum    = A + B;
    diff   = A - B;
    r_lo   = '0;
    r_hi   = '0;
    r_of   = 1'b0;
    r_dz   = 1'b0;
    r_iter = 1'b0;
    case (ALUctr)
      OP_ADD: begin
        r_lo = sum;
        r_of = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        r_lo = diff;
        r_of = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_OR:    r_lo = A | B;
      OP_PASSB: r_lo = B;
      OP_AND:   r_lo = A & B;
      OP_XOR:   r_lo = A ^ B;
      OP_SLT:   r_lo = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:  r_lo = {{(W-1){1'b0}}, A < B};
      OP_MULU:  r_iter = 1'b1;
`ifdef ALU_MDU_DIV_EN
      OP_DIVU: begin
        // Divide by zero resolves in one cycle without iterating.
        if (B == '0) begin
          r_lo = '1;
          r_hi = A;
          r_dz = 1'b1;
        end else begin
          r_iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    trap = r_of && ovf_chk;
  end

  // One iteration step: shift-add multiply, or restoring divide.
  always_comb begin
    madd = {1'b0, ph} + (pl[0] ? {1'b0, mcand} : '0);
    ph_n = madd[W:1];
    pl_n = {madd[0], pl[W-1:1]};
`ifdef ALU_MDU_DIV_EN
    shl   = {ph, pl[W-1]};
    trial = shl - {1'b0, mcand};
    if (is_div) begin
      if (!trial[W]) begin
        ph_n = trial[W-1:0];
        pl_n = {pl[W-2:0], 1'b1};
      end else begin
        ph_n = shl[W-1:0];
        pl_n = {pl[W-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && r_iter) state_n = RUN;
      RUN:  if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ph       <= '0;
      pl       <= '0;
      mcand    <= '0;
      done     <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      Zero     <= 1'b0;
      OF       <= 1'b0;
      div_zero <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        ph  <= ph_n;
        pl  <= pl_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          cnt      <= '0;
          done     <= 1'b1;
          lo       <= pl_n;
          hi       <= ph_n;
          Zero     <= (pl_n == '0);
          OF       <= 1'b0;
          div_zero <= 1'b0;
        end
      end else if (accept) begin
        if (r_iter) begin
          ph    <= '0;
          pl    <= B;
          mcand <= A;
          cnt   <= '0;
`ifdef ALU_MDU_DIV_EN
          is_div <= (ALUctr == OP_DIVU);
          if (ALUctr == OP_DIVU) begin
            pl    <= A;
            mcand <= B;
          end
`endif
        end else begin
          done     <= 1'b1;
          OF       <= trap;
          div_zero <= r_dz;
          // A trapped overflow suppresses writeback.
          if (!trap) begin
            lo   <= r_lo;
            hi   <= r_hi;
            Zero <= (r_lo == '0);
          end else begin
            Zero <= (lo == '0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (W=32).
// Inputs driven 1 time unit after rising edges; outputs sampled there too.
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   ALUctr = 4'b0;
  logic         ovf_chk = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Zero, OF, div_zero;
  logic [W-1:0] lo, hi;

  int checks = 0;
  int errors = 0;
  int n;
  bit seen;

  alu_mdu #(.W(W), .CW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUctr(ALUctr),
    .ovf_chk(ovf_chk), .A(A), .B(B), .busy(busy), .done(done),
    .lo(lo), .hi(hi), .Zero(Zero), .OF(OF), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic go(input logic [3:0] op, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic ovf);
    ALUctr  = op;
    A       = a;
    B       = b;
    ovf_chk = ovf;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lohi", {hi, lo}, 0);
    chk("rst_flags", {Zero, OF, div_zero}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a MULU
    go(4'b1000, 7, 9, 0);
    chk("mul_busy0", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_lohi", {hi, lo}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("mrst_nodone", seen, 0);

    // Overflow trap and wrap
    go(4'b0000, 2, 3, 0);
    chk("add_lo", lo, 5);
    chk("add_done", done, 1);
    go(4'b0000, 32'h7FFFFFFF, 1, 1);
    chk("ovf_done", done, 1);
    chk("ovf_of", OF, 1);
    chk("ovf_lo", lo, 5);
    go(4'b0000, 32'h7FFFFFFF, 1, 0);
    chk("wrap_lo", lo, 32'h80000000);
    chk("wrap_of", OF, 0);
    go(4'b0001, 32'h80000000, 1, 1);
    chk("subovf_of", OF, 1);
    chk("subovf_lo", lo, 32'h80000000);

    // Logic / compare
    go(4'b0001, 32'h1234, 32'h1234, 1);
    chk("sub_lo", lo, 0);
    chk("sub_zero", Zero, 1);
    chk("sub_of", OF, 0);
    go(4'b0110, 32'hFFFFFFFF, 0, 0);
    chk("slt", lo, 1);
    chk("slt_zero", Zero, 0);
    go(4'b0111, 32'hFFFFFFFF, 0, 0);
    chk("sltu", lo, 0);
    go(4'b0100, 32'hF0F0, 32'hFF00, 0);
    chk("and", lo, 32'hF000);
    go(4'b0101, 32'hF0F0, 32'hFF00, 0);
    chk("xor", lo, 32'h0FF0);
    go(4'b0011, 32'h1, 32'hABCD, 0);
    chk("passb", {hi, lo}, 64'hABCD);
    go(4'b1111, 32'h5, 32'h6, 0);
    chk("rsvd_lohi", {hi, lo}, 0);
    chk("rsvd_done", done, 1);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);

    // MULU with a start pulse ignored mid-run
    go(4'b1000, 32'hFFFFFFFF, 2, 0);
    chk("mulu_busy", busy, 1);
    chk("mulu_nodone", done, 0);
    n = 0;
    while (!done && n < 40) begin
      if (n == 9) begin
        start  = 1'b1;
        ALUctr = 4'b0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("mulu_lat", n, 32);
    chk("mulu_prod", {hi, lo}, 64'h1_FFFFFFFE);
    chk("mulu_idle", busy, 0);
    chk("mulu_of", OF, 0);

`ifdef ALU_MDU_DIV_EN
    go(4'b1001, 100, 7, 0);
    chk("divu_busy", busy, 1);
    wait_done(n);
    chk("divu_lat", n, 32);
    chk("divu_q", lo, 14);
    chk("divu_r", hi, 2);
    chk("divu_dz", div_zero, 0);
    go(4'b1001, 100, 0, 0);
    chk("dz_done", done, 1);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 100);
    chk("dz_flag", div_zero, 1);
`else
    go(4'b1001, 100, 7, 0);
    chk("nodiv_done", done, 1);
    chk("nodiv_busy", busy, 0);
    chk("nodiv_lohi", {hi, lo}, 0);
    chk("nodiv_dz", div_zero, 0);
`endif

    // Back-to-back: OR then MULU accepted in the done cycle
    ALUctr = 4'b0010;
    A = 32'hF0;
    B = 32'h0F;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_or_done", done, 1);
    chk("b2b_or_lo", lo, 32'hFF);
    ALUctr = 4'b1000;
    A = 3;
    B = 5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done0", done, 0);
    wait_done(n);
    chk("b2b_lat", n, 32);
    chk("b2b_prod", {hi, lo}, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle processor's combinational ALU. It registers all results, widens the opcode set (logic, set-less-than) and adds an iterative unsigned multiply/divide unit behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle datapath; the control FSM stalls on `busy`.

## Interface
- `W`, 32: operand/result width (≥ 4)
- `CW`, 6: iteration-counter width (must satisfy 2^CW > W)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  operation request; sampled on `clk` only when `busy`=0
- `ALUctr`  in  4  opcode (see Operation)
- `ovf_chk`  in  1  1 = signed-overflow trap enabled for ADD/SUB (addi/add)
- `A`, `B`  in  W  operands
- `busy`  out  1  iterative op in progress
- `done`  out  1  one-cycle pulse: `lo`/`hi`/flags valid
- `lo`  out  W  primary result / product low / quotient
- `hi`  out  W  product high / remainder; 0 for single-cycle ops
- `Zero`  out  1  `lo`==0 at `done`
- `OF`  out  1  signed overflow trapped
- `div_zero`  out  1  DIVU with B==0

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 OR, 0011 PASSB, 0100 AND, 0101 XOR, 0110 SLT (signed, lo = 0/1), 0111 SLTU, 1000 MULU, 1001 DIVU; 1010–1111 reserved → lo=0, hi=0, done pulses.
- Single-cycle ops: A/B/ALUctr/ovf_chk captured and result written on accepting edge.
- ADD/SUB overflow (ADD: A[W-1]==B[W-1] and sum[W-1]!=A[W-1]; SUB: A[W-1]!=B[W-1] and diff[W-1]!=A[W-1]) with `ovf_chk`=1: OF=1, `lo` and `hi` hold their previous values (no writeback). `ovf_chk`=0: wraps modulo 2^W, OF=0.
- MULU: shift-add, one multiplier bit per cycle, full 2W-bit product {hi,lo}.
- DIVU: restoring, one quotient bit per cycle; lo = A/B, hi = A%B.
- DIVU with B==0: no iteration; lo = all ones, hi = A, div_zero=1, single-cycle latency.
- FSM: IDLE → (start, iterative op) RUN → counter reaches W → IDLE with done. Single-cycle ops stay in IDLE.
- Flags (OF, div_zero, Zero) are updated at each `done` and held until the next `done`; OF=0 for all non-ADD/SUB ops.
- Operands are latched internally; A/B may change during RUN.

## Timing
- Reset: busy=0, done=0, lo=0, hi=0, Zero=0, OF=0, div_zero=0, FSM=IDLE, counter=0.
- Accepting edge = edge 0 (start=1, busy=0).
- Single-cycle op: results valid and done=1 after edge 0 (latency 1).
- MULU/DIVU: busy=1 after edge 0; iterations on edges 1..W; after edge W: done=1, busy=0, results valid (latency W+1 cycles).
- start while busy=1: ignored, no queueing.
- start in the cycle done=1: accepted (back-to-back, no bubble).
- done is never high two consecutive cycles unless a new op was accepted.
- rst mid-RUN: aborts immediately, all outputs to reset values, no done.

## Configuration
- `ALU_MDU_DIV_EN` defined: DIVU implemented as above.
- Not defined: divider datapath removed; opcode 1001 treated as reserved (lo=0, hi=0, div_zero=0, single-cycle done).

## Test plan
- Reset mid-MULU (A=7,B=9, rst at cycle 5) → busy=0, done never pulses, lo=hi=0.
- ADD A=32'h7FFFFFFF, B=1, ovf_chk=1 after prior lo=5 → done next cycle, OF=1, lo=5; same with ovf_chk=0 → lo=32'h80000000, OF=0.
- SUB A=B=32'h1234 → lo=0, Zero=1; SLT A=32'hFFFFFFFF, B=0 → lo=1; SLTU same → lo=0.
- MULU A=32'hFFFFFFFF, B=2 → done 33 cycles after accept, hi=1, lo=32'hFFFFFFFE; start pulsed at cycle 10 of RUN ignored.
- DIVU A=100, B=7 (DIV_EN) → after 33 cycles lo=14, hi=2; B=0 → after 1 cycle lo=32'hFFFFFFFF, hi=100, div_zero=1.
- Back-to-back: start held with OR then MULU in done cycle → second op accepted with no idle cycle; without DIV_EN, opcode 1001 → lo=0, done after 1 cycle.
